lsu_initiator: RTL and testbench

Load/store initiator sitting between the core's execute stage and the data-memory bus. It accepts one load or store request at a time, using the codebase size encoding (1/2/4 bytes) and sign flag. It drives word-aligned memory beats with byte enables and splits misaligned accesses into two beats. It reassembles and extends load data, then returns a single-cycle response to the pipeline.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_load_align.sv | 26 ++
 rtl/lsu_initiator.sv | 167 ++++++++++++++++
 tb/tb_lsu_initiator.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator.
package lsu_pkg;

    // Access size encoding used by the execute stage (bytes per access).
    localparam logic [2:0] SZ_BYTE = 3'd1;
    localparam logic [2:0] SZ_HALF = 3'd2;
    localparam logic [2:0] SZ_WORD = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        RESP,
        ERR
    } lsu_state_e;

    // Byte mask of an access anchored at lane 0; all-zero marks an illegal size.
    function automatic logic [3:0] size_mask(input logic [2:0] size);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001;
            SZ_HALF: m = 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data alignment: pulls the addressed bytes out of one or
// two bus words and zero/sign-extends them to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_size,
    input  logic        i_sign,
    input  logic [31:0] i_rdata0,
    input  logic [31:0] i_rdata1,
    output logic [31:0] o_data
);

    logic [31:0] w_raw;

    // Shift the two-word window down by the byte offset, then extend by size.
    always_comb begin
        w_raw = 32'({i_rdata1, i_rdata0} >> {i_off, 3'b000});
        case (i_size)
            SZ_BYTE: o_data = {{24{i_sign & w_raw[7]}}, w_raw[7:0]};
            SZ_HALF: o_data = {{16{i_sign & w_raw[15]}}, w_raw[15:0]};
            default: o_data = w_raw;
        endcase
    end

endmodule

// File: rtl/lsu_initiator.sv
// Load/store initiator: accepts one pipeline request at a time, issues one or
// two word-aligned bus beats, and returns a single-cycle response.
module lsu_initiator
    import lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_size,
    input  logic              req_sign,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        r_state;
    lsu_state_e        w_next;

    logic              r_store;
    logic              r_sign;
    logic              r_split;
    logic [1:0]        r_off;
    logic [2:0]        r_size;
    logic [3:0]        r_mask;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata0;
    logic [31:0]       r_rdata1;

    logic              w_accept;
    logic              w_legal;
    logic              w_split;
    logic [3:0]        w_be0;
    logic [3:0]        w_be1;
    logic [31:0]       w_wdata0;
    logic [31:0]       w_wdata1;
    logic [5:0]        w_sh1;
    logic [31:0]       w_load;

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_legal  = (size_mask(req_size) != 4'b0000);
    assign w_split  = ({2'b00, req_addr[1:0]} + {1'b0, req_size}) > 4'd4;

    // Lane placement of both beats, derived from the captured request.
    assign w_sh1    = {3'd4 - {1'b0, r_off}, 3'b000};
    assign w_be0    = 4'({4'b0000, r_mask} << r_off);
    assign w_be1    = r_mask >> (3'd4 - {1'b0, r_off});
    assign w_wdata0 = r_wdata << {r_off, 3'b000};
    assign w_wdata1 = r_wdata >> w_sh1;

    lsu_load_align u_align (
        .i_off    (r_off),
        .i_size   (r_size),
        .i_sign   (r_sign),
        .i_rdata0 (r_rdata0),
        .i_rdata1 (r_rdata1),
        .o_data   (w_load)
    );

    // State register plus request capture and read-word capture.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state  <= IDLE;
            r_store  <= 1'b0;
            r_sign   <= 1'b0;
            r_split  <= 1'b0;
            r_off    <= 2'd0;
            r_size   <= 3'd0;
            r_mask   <= 4'd0;
            r_base   <= '0;
            r_wdata  <= 32'd0;
            r_rdata0 <= 32'd0;
            r_rdata1 <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_store  <= req_store;
                r_sign   <= req_sign;
                r_split  <= w_split;
                r_off    <= req_addr[1:0];
                r_size   <= req_size;
                r_mask   <= size_mask(req_size);
                r_base   <= {req_addr[ADDR_W-1:2], 2'b00};
                r_wdata  <= req_wdata;
                r_rdata0 <= 32'd0;
                r_rdata1 <= 32'd0;
            end
            if (r_state == WAIT0 && mem_rvalid) r_rdata0 <= mem_rdata;
            if (r_state == WAIT1 && mem_rvalid) r_rdata1 <= mem_rdata;
        end
    end

    // Next-state decode and all bus/response outputs, purely from state.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_next     = r_state;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = 4'd0;
        mem_wdata  = 32'd0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!w_legal || (w_split && !ALLOW_MISALIGNED)) w_next = ERR;
                    else                                             w_next = REQ0;
                end
            end
            REQ0: begin
                mem_req   = 1'b1;
                mem_we    = r_store;
                mem_addr  = r_base;
                mem_be    = w_be0;
                mem_wdata = r_store ? w_wdata0 : 32'd0;
                if (mem_gnt) w_next = WAIT0;
            end
            WAIT0: begin
                if (mem_rvalid) w_next = r_split ? REQ1 : RESP;
            end
            REQ1: begin
                mem_req   = 1'b1;
                mem_we    = r_store;
                mem_addr  = r_base + ADDR_W'(4);
                mem_be    = w_be1;
                mem_wdata = r_store ? w_wdata1 : 32'd0;
                if (mem_gnt) w_next = WAIT1;
            end
            WAIT1: begin
                if (mem_rvalid) w_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = r_store ? 32'd0 : w_load;
                w_next     = IDLE;
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_initiator.sv
// Self-checking bench for lsu_initiator: table of transactions driven through
// a simple bus responder, responses checked against a scoreboard queue.
module tb_lsu_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_valid_nm = 1'b0;
    logic        req_store = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_size = 3'd0;
    logic        req_sign = 1'b0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        nm_req_ready, nm_resp_valid, nm_resp_err, nm_mem_req, nm_mem_we;
    logic [31:0] nm_resp_rdata, nm_mem_addr, nm_mem_wdata;
    logic [3:0]  nm_mem_be;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lsu_initiator #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_sign(req_sign),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_initiator #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) dut_nm (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_nm), .req_ready(nm_req_ready), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_sign(req_sign),
        .resp_valid(nm_resp_valid), .resp_rdata(nm_resp_rdata), .resp_err(nm_resp_err),
        .mem_req(nm_mem_req), .mem_gnt(mem_gnt), .mem_we(nm_mem_we), .mem_addr(nm_mem_addr),
        .mem_be(nm_mem_be), .mem_wdata(nm_mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        string       name;
        bit          store;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        bit          sign;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          gnt_dly;
        int          nbeats;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    vec_t  vecs[$];
    resp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Drive one request and act as the bus slave until its response appears.
    task automatic run_txn(input vec_t v);
        int    beat = 0;
        int    wcnt = 0;
        int    exp_lat;
        bit    done = 1'b0;
        bit    rv_pend = 1'b0;
        resp_t r;
        exp_lat = 2 * v.nbeats + v.nbeats * v.gnt_dly;
        sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(negedge clk);
        check({v.name, " ready"}, req_ready, 1'b1);
        req_valid = 1'b1;  // held high through the transaction: must not be re-accepted
        req_store = v.store;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_size  = v.size;
        req_sign  = v.sign;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'd0;
            if (cyc == 0) check({v.name, " busy_ready"}, req_ready, 1'b0);
            if (resp_valid) begin
                check({v.name, " latency"}, cyc, exp_lat);
                check({v.name, " beats"}, beat, v.nbeats);
                if (sb_q.size() == 0) begin
                    check({v.name, " unexpected_resp"}, 1'b1, 1'b0);
                end else begin
                    r = sb_q.pop_front();
                    check({v.name, " rdata"}, resp_rdata, r.rdata);
                    check({v.name, " err"}, resp_err, r.err);
                end
                done      = 1'b1;
                req_valid = 1'b0;
            end else if (rv_pend) begin
                check({v.name, " req_drop"}, mem_req, 1'b0);
                mem_rvalid = 1'b1;
                mem_rdata  = (beat == 1) ? v.rd0 : v.rd1;
                rv_pend    = 1'b0;
            end else if (mem_req) begin
                if (beat >= v.nbeats) begin
                    check({v.name, " extra_beat"}, beat, v.nbeats - 1);
                end else begin
                    check({v.name, " addr"}, mem_addr, (beat == 0) ? v.a0 : v.a1);
                    check({v.name, " be"}, mem_be, (beat == 0) ? v.be0 : v.be1);
                    check({v.name, " we"}, mem_we, v.store);
                    if (v.store) check({v.name, " wdata"}, mem_wdata, (beat == 0) ? v.wd0 : v.wd1);
                end
                if (wcnt == v.gnt_dly) begin
                    mem_gnt = 1'b1;
                    beat++;
                    wcnt    = 0;
                    rv_pend = 1'b1;
                end else begin
                    wcnt++;
                end
            end
        end
        if (!done) begin
            check({v.name, " timeout"}, 1'b0, 1'b1);
            req_valid = 1'b0;
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          name          st addr          wdata         sz sg rd0           rd1           gd nb a0            be0      wd0           a1            be1      wd1           rdata         err
        vecs.push_back('{"st_w_al",   1, 32'h100,      32'hDEADBEEF, 4, 0, 0,            0,            0, 1, 32'h100,      4'b1111, 32'hDEADBEEF, 0,            0,       0,            32'h0,        0});
        vecs.push_back('{"st_w_mis",  1, 32'h102,      32'hDEADBEEF, 4, 0, 0,            0,            0, 2, 32'h100,      4'b1100, 32'hBEEF0000, 32'h104,      4'b0011, 32'h0000DEAD, 32'h0,        0});
        vecs.push_back('{"ld_h_s",    0, 32'h103,      0,            2, 1, 32'h12345678, 32'h9ABCDEF0, 0, 2, 32'h100,      4'b1000, 0,            32'h104,      4'b0001, 0,            32'hFFFFF012, 0});
        vecs.push_back('{"ld_h_u",    0, 32'h103,      0,            2, 0, 32'h12345678, 32'h9ABCDEF0, 0, 2, 32'h100,      4'b1000, 0,            32'h104,      4'b0001, 0,            32'h0000F012, 0});
        vecs.push_back('{"ld_b_s",    0, 32'h102,      0,            1, 1, 32'h11A23344, 0,            3, 1, 32'h100,      4'b0100, 0,            0,            0,       0,            32'hFFFFFFA2, 0});
        vecs.push_back('{"ld_b_u",    0, 32'h102,      0,            1, 0, 32'h11A23344, 0,            1, 1, 32'h100,      4'b0100, 0,            0,            0,       0,            32'h000000A2, 0});
        vecs.push_back('{"sz3_err",   0, 32'h100,      0,            3, 0, 0,            0,            0, 0, 0,            0,       0,            0,            0,       0,            32'h0,        1});
        vecs.push_back('{"sz0_err",   1, 32'h104,      32'h55,       0, 0, 0,            0,            0, 0, 0,            0,       0,            0,            0,       0,            32'h0,        1});
        vecs.push_back('{"ld_w_al",   0, 32'h204,      0,            4, 1, 32'hCAFEF00D, 0,            0, 1, 32'h204,      4'b1111, 0,            0,            0,       0,            32'hCAFEF00D, 0});
        vecs.push_back('{"st_b_hi",   1, 32'h107,      32'h123456AB, 1, 0, 0,            0,            2, 1, 32'h104,      4'b1000, 32'hAB000000, 0,            0,       0,            32'h0,        0});
        vecs.push_back('{"st_h_mid",  1, 32'h101,      32'h1234BEEF, 2, 0, 0,            0,            0, 1, 32'h100,      4'b0110, 32'h34BEEF00, 0,            0,       0,            32'h0,        0});
        vecs.push_back('{"ld_w_wrap", 0, 32'hFFFFFFFE, 0,            4, 0, 32'hAABBCCDD, 32'h11223344, 1, 2, 32'hFFFFFFFC, 4'b1100, 0,            32'h00000000, 4'b0011, 0,            32'h3344AABB, 0});

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst req_ready", req_ready, 1'b1);
        check("rst mem_req", mem_req, 1'b0);
        check("rst mem_we", mem_we, 1'b0);
        check("rst mem_be", mem_be, 4'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst resp_valid", resp_valid, 1'b0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst resp_err", resp_err, 1'b0);
        check("rst nm_ready", nm_req_ready, 1'b1);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Word-crossing access with misalignment disallowed: error, no bus traffic.
        @(negedge clk);
        req_store    = 1'b1;
        req_addr     = 32'h101;
        req_size     = 3'd4;
        req_wdata    = 32'h01020304;
        req_valid_nm = 1'b1;
        @(negedge clk);
        req_valid_nm = 1'b0;
        check("nm resp_valid", nm_resp_valid, 1'b1);
        check("nm resp_err", nm_resp_err, 1'b1);
        check("nm resp_rdata", nm_resp_rdata, 32'd0);
        check("nm mem_req", nm_mem_req, 1'b0);
        @(negedge clk);
        check("nm resp_drop", nm_resp_valid, 1'b0);
        check("nm err_drop", nm_resp_err, 1'b0);
        check("nm mem_req2", nm_mem_req, 1'b0);
        check("nm ready", nm_req_ready, 1'b1);

        // Reset while waiting for read data abandons the transaction.
        @(negedge clk);
        req_store = 1'b0;
        req_addr  = 32'h100;
        req_size  = 3'd4;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstw mem_req", mem_req, 1'b1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rstw wait", mem_req, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw ready", req_ready, 1'b1);
        check("rstw mem_req0", mem_req, 1'b0);
        check("rstw no_resp", resp_valid, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFEEDFACE;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("late_rvalid no_resp", resp_valid, 1'b0);
        check("late_rvalid ready", req_ready, 1'b1);
        check("late_rvalid mem_req", mem_req, 1'b0);

        run_txn('{"ld_after_rst", 0, 32'h200, 0, 4, 0, 32'h0BADF00D, 0, 0, 1, 32'h200, 4'b1111, 0, 0, 0, 0, 32'h0BADF00D, 0});

        check("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
